// File: rtl/modulus_seq_pkg.sv
// Shared types for the modulus LUT sequencer.
// Holds the FSM state encoding and the default counter width.
package modulus_seq_pkg;

  localparam int ITER_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/modulus_seq_counter.sv
// Clearable up-counter with a compare against a limit.
// LOOKAHEAD=1 flags the increment that will reach the limit.
module modulus_seq_counter
  import modulus_seq_pkg::*;
#(
  parameter int W         = ITER_W_DEF,
  parameter bit LOOKAHEAD = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_hit
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_plus1;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= w_plus1;
    end
  end

  assign w_plus1 = r_count + W'(1);
  assign o_count = r_count;
  assign o_hit   = LOOKAHEAD ? (w_plus1 == i_limit)
                             : (r_count == i_limit);

endmodule

// File: rtl/modulus_lut_sequencer.sv
// Sequences squarer upper-bit words into the modulus LUT chunks.
// Define MODULUS_SEQ_STALL_CNT_EN to add the stall_cycles port.
module modulus_lut_sequencer
  import modulus_seq_pkg::*;
#(
  parameter int BIT_LEN = 51,
  parameter int ITER_W  = ITER_W_DEF
) (
  input  logic              clk_phase,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIT_LEN-1:0] in_addr,
  output logic              lut_ce,
  output logic              lut_bypass,
  output logic [BIT_LEN-1:0] lut_addr,
  output logic              terms_valid,
  input  logic              terms_ready,
  output logic [ITER_W-1:0] iter_count
`ifdef MODULUS_SEQ_STALL_CNT_EN
  ,
  output logic [ITER_W-1:0] stall_cycles
`endif
);

  state_e            r_state;
  state_e            w_next;
  logic [ITER_W-1:0] r_num_iter;
  logic              r_terms_valid;
  logic [ITER_W-1:0] w_issued;
  logic              w_iss_full;
  logic              w_iter_last;
  logic              w_start_job;
  logic              w_accept;
  logic              w_hs;
  logic              w_run;

  assign w_run       = (r_state == ST_RUN);
  assign w_start_job = (r_state == ST_IDLE) && start;
  assign w_hs        = r_terms_valid && terms_ready;

  // Issue only while the output slot is free or draining this cycle.
  assign in_ready = w_run && !w_iss_full &&
                    (!r_terms_valid || terms_ready);
  assign w_accept = in_valid && in_ready;

  assign lut_ce      = w_accept;
  assign lut_addr    = in_addr;
  assign lut_bypass  = 1'b0;
  assign terms_valid = r_terms_valid;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

  modulus_seq_counter #(
    .W         (ITER_W),
    .LOOKAHEAD (1'b0)
  ) u_issued (
    .i_clk   (clk_phase),
    .i_rst   (reset),
    .i_clr   (w_start_job),
    .i_inc   (w_accept),
    .i_limit (r_num_iter),
    .o_count (w_issued),
    .o_hit   (w_iss_full)
  );

  modulus_seq_counter #(
    .W         (ITER_W),
    .LOOKAHEAD (1'b1)
  ) u_iter (
    .i_clk   (clk_phase),
    .i_rst   (reset),
    .i_clr   (w_start_job),
    .i_inc   (w_hs),
    .i_limit (r_num_iter),
    .o_count (iter_count),
    .o_hit   (w_iter_last)
  );

  always_ff @(posedge clk_phase) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_phase) begin
    if (reset) begin
      r_num_iter <= '0;
    end else if (w_start_job) begin
      r_num_iter <= num_iter;
    end
  end

  always_ff @(posedge clk_phase) begin
    if (reset) begin
      r_terms_valid <= 1'b0;
    end else if (w_accept) begin
      r_terms_valid <= 1'b1;
    end else if (w_hs) begin
      r_terms_valid <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (num_iter == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_hs && w_iter_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // issued never exceeds num_iter, so only w_issued's compare is used.
  logic w_unused;
  assign w_unused = ^w_issued;

`ifdef MODULUS_SEQ_STALL_CNT_EN
  logic [ITER_W-1:0] r_stall;

  always_ff @(posedge clk_phase) begin
    if (reset || w_start_job) begin
      r_stall <= '0;
    end else if (w_run && r_terms_valid && !terms_ready) begin
      r_stall <= r_stall + ITER_W'(1);
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_modulus_lut_sequencer.sv
// Bench for modulus_lut_sequencer: directed jobs plus random traffic
// checked cycle by cycle against a job-level reference model.
module tb_modulus_lut_sequencer;

  localparam int BL = 51;
  localparam int IW = 32;

  logic          clk_phase = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] num_iter;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] in_addr;
  logic          lut_ce;
  logic          lut_bypass;
  logic [BL-1:0] lut_addr;
  logic          terms_valid;
  logic          terms_ready;
  logic [IW-1:0] iter_count;
`ifdef MODULUS_SEQ_STALL_CNT_EN
  logic [IW-1:0] stall_cycles;
`endif

  modulus_lut_sequencer #(
    .BIT_LEN (BL),
    .ITER_W  (IW)
  ) dut (
    .clk_phase   (clk_phase),
    .reset       (reset),
    .start       (start),
    .num_iter    (num_iter),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .lut_ce      (lut_ce),
    .lut_bypass  (lut_bypass),
    .lut_addr    (lut_addr),
    .terms_valid (terms_valid),
    .terms_ready (terms_ready),
    .iter_count  (iter_count)
`ifdef MODULUS_SEQ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk_phase = ~clk_phase;

  int checks   = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: 0=idle 1=run 2=done
  int          m_phase;
  longint      m_n;
  longint      m_iss;
  longint      m_cnt;
  longint      m_stall;
  bit          m_tv;

  int jc;
  int done_at;
  int ce_cnt;

  task automatic model_reset();
    m_phase = 0;
    m_n     = 0;
    m_iss   = 0;
    m_cnt   = 0;
    m_stall = 0;
    m_tv    = 0;
  endtask

  function automatic logic [BL-1:0] rnd_addr();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[BL-1:0];
  endfunction

  task automatic step(bit rs, bit st, logic [IW-1:0] n,
                      bit iv, bit tr, logic [BL-1:0] a);
    bit e_rdy;
    bit acc;
    bit hs;
    @(negedge clk_phase);
    reset       = rs;
    start       = st;
    num_iter    = n;
    in_valid    = iv;
    terms_ready = tr;
    in_addr     = a;
    #1;
    e_rdy = (m_phase == 1) && (m_iss < m_n) && (!m_tv || tr);
    acc   = iv && e_rdy;
    hs    = m_tv && tr;
    check("busy",        busy,        m_phase != 0);
    check("done",        done,        m_phase == 2);
    check("in_ready",    in_ready,    e_rdy);
    check("lut_ce",      lut_ce,      acc);
    check("lut_bypass",  lut_bypass,  1'b0);
    check("lut_addr",    lut_addr,    a);
    check("terms_valid", terms_valid, m_tv);
    check("iter_count",  iter_count,  m_cnt);
`ifdef MODULUS_SEQ_STALL_CNT_EN
    check("stall_cycles", stall_cycles, m_stall);
`endif
    if (done) done_at = jc;
    if (lut_ce) ce_cnt++;
    jc++;
    if (rs) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (st) begin
          m_n     = longint'(n);
          m_iss   = 0;
          m_cnt   = 0;
          m_stall = 0;
          m_phase = (n == 0) ? 2 : 1;
        end
        1: begin
          if (m_tv && !tr) m_stall++;
          if (acc) m_iss++;
          if (hs) m_cnt++;
          if (acc) m_tv = 1;
          else if (hs) m_tv = 0;
          if (hs && m_cnt == m_n) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One job with optional terms_ready stall window and a repeat start.
  task automatic job(int n, int total, int st_from, int st_len,
                     int again_at);
    bit st;
    bit tr;
    jc      = 0;
    done_at = -1;
    ce_cnt  = 0;
    for (int c = 0; c < total; c++) begin
      st = (c == 0) || (c == again_at);
      tr = !(c >= st_from && c < st_from + st_len);
      step(1'b0, st, (c == 0) ? IW'(n) : IW'(n + 5), 1'b1, tr,
           rnd_addr());
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    num_iter    = '0;
    in_valid    = 1'b0;
    terms_ready = 1'b0;
    in_addr     = '0;
    model_reset();
    repeat (2) @(posedge clk_phase);
    #1;
    check("rst_busy",  busy,        1'b0);
    check("rst_done",  done,        1'b0);
    check("rst_tv",    terms_valid, 1'b0);
    check("rst_ready", in_ready,    1'b0);
    check("rst_ce",    lut_ce,      1'b0);
    check("rst_cnt",   iter_count,  '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);

    // Back-to-back three lookups
    job(3, 8, 99, 0, -1);
    check("j3_done_cycle", done_at, 5);
    check("j3_ce_count",   ce_cnt,  3);
    check("j3_iter",       iter_count, 3);

    // Empty job
    job(0, 4, 99, 0, -1);
    check("j0_done_cycle", done_at, 1);
    check("j0_ce_count",   ce_cnt,  0);

    // Four-cycle consumer stall on the first terms
    job(2, 11, 2, 4, -1);
    check("stall_done_cycle", done_at, 8);
    check("stall_ce_count",   ce_cnt,  2);
    check("stall_iter",       iter_count, 2);
`ifdef MODULUS_SEQ_STALL_CNT_EN
    check("stall_count", stall_cycles, 4);
`endif

    // Restart attempt mid-job is ignored
    job(3, 8, 99, 0, 2);
    check("restart_done_cycle", done_at, 5);
    check("restart_iter",       iter_count, 3);

    // Reset mid-job after one completed lookup
    job(3, 3, 99, 0, -1);
    @(posedge clk_phase);
    #1;
    check("mid_cnt_before", iter_count, 1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, rnd_addr());
    jc      = 0;
    done_at = -1;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, rnd_addr());
    end
    check("mid_no_done", done_at, -1);
    check("mid_iter",    iter_count, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bit rs;
      bit st;
      rs = ($urandom_range(0, 199) == 0);
      st = (m_phase == 0) ? ($urandom_range(0, 3) == 0)
                          : ($urandom_range(0, 9) == 0);
      step(rs, st, IW'($urandom_range(0, 6)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, rnd_addr());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modulus_lut_sequencer.md
MODULUS_LUT_SEQUENCER -- requirements
Module: modulus_lut_sequencer

Interface
REQ-001 SHALL have parameter BIT_LEN, default 51: width of the LUT address word taken from the squarer upper bits.
REQ-002 SHALL have parameter ITER_W, default 32: width of the iteration count and counters.
REQ-003 SHALL have one clock, clk_phase; reset is synchronous and active-high, port reset.
REQ-004 Ports, in this order:
- clk_phase, input, 1: clock.
- reset, input, 1: synchronous reset, active-high.
- start, input, 1: begin a job; sampled only in IDLE.
- num_iter, input, ITER_W: number of LUT lookups in the job; latched on start.
- busy, output, 1: job in progress.
- done, output, 1: one-cycle job-complete pulse.
- in_valid, input, 1: an upper-bits word is offered.
- in_ready, output, 1: the sequencer accepts the word.
- in_addr, input, BIT_LEN: the upper-bits word.
- lut_ce, output, 1: clock enable to the LUT chunk registers and BRAMs.
- lut_bypass, output, 1: quint register bypass select.
- lut_addr, output, BIT_LEN: LUT chunk address.
- terms_valid, output, 1: the chunk's moduli_terms are valid.
- terms_ready, input, 1: consumer (reduction adder tree) takes the terms.
- iter_count, output, ITER_W: completed lookups in the current job.

Function
REQ-005 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-006 IDLE SHALL go to RUN on start=1 and latch num_iter; if num_iter=0 it SHALL go to DONE instead.
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 in_ready SHALL be 1 only when all hold: state RUN; issued < num_iter; terms_valid=0 or terms_ready=1. in_ready SHALL be combinational from terms_ready.
REQ-009 An accept is the cycle where in_valid and in_ready are both 1. lut_ce SHALL equal accept in that same cycle, and lut_addr SHALL equal in_addr combinationally.
REQ-010 lut_bypass SHALL be constant 0, so the quint and nonuple terms align at exactly one cycle of latency.
REQ-011 terms_valid SHALL rise in the cycle after an accept.
- It SHALL stay 1 while terms_ready=0.
- It SHALL clear after a handshake unless a new accept occurs in that same cycle.
REQ-012 While terms_valid=1 and terms_ready=0, lut_ce SHALL be 0 so that the chunk outputs are held.
REQ-013 The issued counter SHALL increment on each accept. iter_count SHALL increment on each terms handshake (terms_valid and terms_ready both 1).
REQ-014 When the handshake that makes iter_count equal num_iter occurs, the FSM SHALL enter DONE in the next cycle.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE. iter_count SHALL keep its final value until the next start, which clears it.
REQ-016 Sustained throughput SHALL be one lookup per cycle when in_valid=1 and terms_ready=1 continuously.
REQ-017 busy SHALL be 1 whenever the state is not IDLE.
REQ-018 Counter widths SHALL be ITER_W bits; num_iter = 2^ITER_W-1 SHALL complete without wrap.

Reset
REQ-019 On reset=1 at a clock edge, regardless of state, the block SHALL reach:
- state IDLE;
- busy=0, done=0, terms_valid=0, in_ready=0, lut_ce=0, lut_bypass=0;
- iter_count=0 and the issued counter cleared.
REQ-020 A reset mid-job SHALL abandon the job; no done pulse SHALL follow.

Configuration
REQ-021 With MODULUS_SEQ_STALL_CNT_EN defined, the block SHALL add the output port stall_cycles [ITER_W-1:0].
- stall_cycles SHALL count RUN cycles where terms_valid=1 and terms_ready=0.
- It SHALL clear on start and on reset.
REQ-022 Without MODULUS_SEQ_STALL_CNT_EN, the port and counter SHALL be absent and behaviour otherwise SHALL be identical.

Structure
REQ-023 Package modulus_seq_pkg SHALL hold the FSM state enum and the default ITER_W constant.
REQ-024 The two counters SHALL use one sub-module, modulus_seq_counter: clear, increment enable and terminal compare against num_iter.

Verification
REQ-025 num_iter=3, in_valid=1, terms_ready=1 from cycle 0, start at cycle 0:
- accepts in cycles 1-3;
- terms_valid high in cycles 2-4;
- done=1 in cycle 5; iter_count=3.
REQ-026 num_iter=0, start=1: done=1 exactly one cycle later; lut_ce never asserted.
REQ-027 num_iter=2, terms_ready=0 for 4 cycles after the first terms_valid:
- in_ready=0 and lut_ce=0 throughout;
- lut_addr changes do not disturb the held terms;
- completion is 4 cycles later than with no stall; with MODULUS_SEQ_STALL_CNT_EN, stall_cycles=4.
REQ-028 reset=1 asserted in RUN with iter_count=1: the next cycle shows IDLE with all outputs at reset values; no done pulse.
REQ-029 start pulsed again during RUN: ignored; num_iter unchanged; job completes on its original count.
